temp_shift_reg: RTL and testbench
=================================

# temp_shift_reg

Single-stage registered data path with an optional one-bit left shift. On each rising clock edge it captures the input word either unchanged or shifted left by one bit, selected by a control input, and holds the result on its output. It sits as a simple pipeline register stage wherever a word may need a ×2 scaling with truncation on the way through.

## Interface

Parameters:
- WIDTH, 32, data word width in bits. All data ports are WIDTH bits; default behaviour below is for 32.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  reset; one clock, reset is synchronous and active-high.
- SHIFT  input  1  mode select: 0 = load DATA_IN as-is, 1 = load DATA_IN shifted left by one.
- DATA_IN  input  WIDTH  input data word.
- DATA_OUT  output  WIDTH  registered output word.

## Operation

- Single WIDTH-bit register drives DATA_OUT directly; no combinational path from inputs to DATA_OUT.
- At each rising CLK edge, priority order:
  - RST = 1: register <= all zeros. SHIFT and DATA_IN ignored.
  - RST = 0, SHIFT = 0: register <= DATA_IN.
  - RST = 0, SHIFT = 1: register <= {DATA_IN[WIDTH-2:0], 1'b0}.
- Shift is logical: bit 0 of result is 0, DATA_IN[WIDTH-1] is discarded, no carry/overflow flag.
- Shift source is always the current DATA_IN, never the previously stored DATA_OUT; consecutive SHIFT cycles do not accumulate.
- No enable: register updates every cycle when not in reset.
- No internal state other than the output register; no FSM.

## Timing

- Latency: one clock. Value computed from inputs sampled at edge N appears on DATA_OUT immediately after edge N and holds until edge N+1.
- Reset value: DATA_OUT = 0 after the first rising edge with RST = 1. Before any clock edge, DATA_OUT is undefined.
- Reset is synchronous: asserting/deasserting RST between edges has no effect until the next rising edge.
- Reset mid-stream: a single RST cycle clears the register; the next non-reset edge loads normally from DATA_IN/SHIFT with no recovery cycles.
- SHIFT may change every cycle; each edge uses only that edge's SHIFT and DATA_IN.
- Inputs must meet setup/hold relative to CLK rising edge; testbench drives inputs away from the active edge (e.g. 10 ns period, changes on falling edge or mid-cycle).

## Test plan

- Reset: RST=1, SHIFT=0, DATA_IN=0xF000_0001, one edge -> DATA_OUT = 0x0000_0000.
- Load: RST=0, SHIFT=0, DATA_IN=0xF000_0001, one edge -> DATA_OUT = 0xF000_0001.
- Shift: RST=0, SHIFT=1, DATA_IN=0xF000_0001, one edge -> DATA_OUT = 0xE000_0002 (MSB dropped, LSB zero-filled).
- No accumulation: RST=0, SHIFT=1, DATA_IN held at 0x0000_0001 for three edges -> DATA_OUT = 0x0000_0002 after every edge.
- Reset priority: RST=1, SHIFT=1, DATA_IN=0xFFFF_FFFF -> DATA_OUT = 0x0000_0000; then RST=0, SHIFT=1 -> 0xFFFF_FFFE.
- Per-cycle mode switch: alternate SHIFT 0/1 with DATA_IN=0x8000_0000 -> DATA_OUT alternates 0x8000_0000 / 0x0000_0000, one-cycle latency each.

Source files
------------

// File: rtl/temp_shift_reg.sv
// Pipeline register stage that captures its input word either unchanged or
// scaled by two (logical left shift by one, MSB truncated) on every clock.
module temp_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SHIFT,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_next;

  // The shift always works on the current input, never on the stored word,
  // so repeated SHIFT cycles do not compound.
  assign w_shifted = {DATA_IN[WIDTH-2:0], 1'b0};
  assign w_next    = SHIFT ? w_shifted : DATA_IN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_data <= '0;
    end else begin
      r_data <= w_next;
    end
  end

  assign DATA_OUT = r_data;

endmodule

// File: tb/tb_temp_shift_reg.sv
// Directed-vector bench for temp_shift_reg: inputs change on the falling edge,
// outputs are sampled 1 ns after the rising edge.
module tb_temp_shift_reg;

  localparam int WIDTH = 32;

  logic             CLK;
  logic             RST;
  logic             SHIFT;
  logic [WIDTH-1:0] DATA_IN;
  logic [WIDTH-1:0] DATA_OUT;

  int vectors;
  int miscompares;

  temp_shift_reg #(.WIDTH(WIDTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SHIFT    (SHIFT),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one set of inputs on the falling edge, then step past the next rising edge.
  task automatic applyStimulus(input logic rst, input logic shift, input logic [WIDTH-1:0] din);
    @(negedge CLK);
    RST     = rst;
    SHIFT   = shift;
    DATA_IN = din;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b0, 32'hF000_0001);
    vectors++;
    if (DATA_OUT !== 32'h0000_0000) begin
      miscompares++;
      $display("[TB] FAIL reset: got %h expected %h", DATA_OUT, 32'h0000_0000);
    end
  endtask

  task automatic test_load();
    applyStimulus(1'b0, 1'b0, 32'hF000_0001);
    vectors++;
    if (DATA_OUT !== 32'hF000_0001) begin
      miscompares++;
      $display("[TB] FAIL load: got %h expected %h", DATA_OUT, 32'hF000_0001);
    end
    applyStimulus(1'b0, 1'b0, 32'h1234_5678);
    vectors++;
    if (DATA_OUT !== 32'h1234_5678) begin
      miscompares++;
      $display("[TB] FAIL load2: got %h expected %h", DATA_OUT, 32'h1234_5678);
    end
  endtask

  task automatic test_shift();
    applyStimulus(1'b0, 1'b1, 32'hF000_0001);
    vectors++;
    if (DATA_OUT !== 32'hE000_0002) begin
      miscompares++;
      $display("[TB] FAIL shift: got %h expected %h", DATA_OUT, 32'hE000_0002);
    end
    applyStimulus(1'b0, 1'b1, 32'h5555_5555);
    vectors++;
    if (DATA_OUT !== 32'hAAAA_AAAA) begin
      miscompares++;
      $display("[TB] FAIL shift_pattern: got %h expected %h", DATA_OUT, 32'hAAAA_AAAA);
    end
    applyStimulus(1'b0, 1'b1, 32'hAAAA_AAAA);
    vectors++;
    if (DATA_OUT !== 32'h5555_5554) begin
      miscompares++;
      $display("[TB] FAIL shift_msb_drop: got %h expected %h", DATA_OUT, 32'h5555_5554);
    end
  endtask

  task automatic test_no_accumulation();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0000_0001);
      vectors++;
      if (DATA_OUT !== 32'h0000_0002) begin
        miscompares++;
        $display("[TB] FAIL no_accum[%0d]: got %h expected %h", i, DATA_OUT, 32'h0000_0002);
      end
    end
  endtask

  task automatic test_reset_priority();
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF);
    vectors++;
    if (DATA_OUT !== 32'h0000_0000) begin
      miscompares++;
      $display("[TB] FAIL rst_priority: got %h expected %h", DATA_OUT, 32'h0000_0000);
    end
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
    vectors++;
    if (DATA_OUT !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("[TB] FAIL rst_recovery: got %h expected %h", DATA_OUT, 32'hFFFF_FFFE);
    end
  endtask

  // RST raised between edges must not disturb the output until the next rising edge.
  task automatic test_sync_reset();
    applyStimulus(1'b0, 1'b0, 32'hCAFE_F00D);
    @(negedge CLK);
    RST = 1'b1;
    #2;
    vectors++;
    if (DATA_OUT !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("[TB] FAIL sync_reset_hold: got %h expected %h", DATA_OUT, 32'hCAFE_F00D);
    end
    @(posedge CLK);
    #1;
    vectors++;
    if (DATA_OUT !== 32'h0000_0000) begin
      miscompares++;
      $display("[TB] FAIL sync_reset_clear: got %h expected %h", DATA_OUT, 32'h0000_0000);
    end
  endtask

  task automatic test_mode_switch();
    logic [WIDTH-1:0] expected;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, i[0], 32'h8000_0000);
      expected = i[0] ? 32'h0000_0000 : 32'h8000_0000;
      vectors++;
      if (DATA_OUT !== expected) begin
        miscompares++;
        $display("[TB] FAIL mode_switch[%0d]: got %h expected %h", i, DATA_OUT, expected);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST     = 1'b0;
    SHIFT   = 1'b0;
    DATA_IN = '0;
    test_reset();
    test_load();
    test_shift();
    test_no_accumulation();
    test_reset_priority();
    test_sync_reset();
    test_mode_switch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
